i2s_dac_serializer: RTL and testbench

Downstream stage of the audio filter chain: takes the 16-bit signed filtered sample and shifts it out MSB-first to the codec DAC data pin in I2S format. Codec-driven BCLK and LRCLK are synchronised into the system clock domain. The block also produces the single-cycle LRCLK edge pulses that pace the filter. Everything runs on the one system clock; BCLK is sampled, never used as a clock.

---
 rtl/i2s_dac_serializer.sv | 136 +++++++++++++
 tb/tb_i2s_dac_serializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - I2S DAC serializer: 16-bit MSB-first shift-out paced by synchronised BCLK/LRCLK.
// Optional feature macro: DAC_STEREO_DUP_EN (right slot repeats the sample; otherwise right slot is zero).
module i2s_dac_serializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_bclk,
    input  logic        i_lrclk,
    input  logic        i_valid,
    input  logic [15:0] i_sample,
    output logic        o_dacdat,
    output logic        o_lrclk_posedge,
    output logic        o_lrclk_negedge,
    output logic        o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrclk_sync_q, lrclk_sync_d;
    logic                   bclk_hist_q, bclk_hist_d;
    logic                   lrclk_hist_q, lrclk_hist_d;

    logic [1:0]  state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dacdat_q, dacdat_d;
    logic        pos_q, pos_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;

    logic        bclk_fall;
    logic        lrclk_rise;
    logic        lrclk_fall;
    logic [15:0] left_word;
    logic [15:0] right_word;

    always_comb begin
        bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], i_bclk};
        lrclk_sync_d = {lrclk_sync_q[SYNC_STAGES-2:0], i_lrclk};
        bclk_hist_d  = bclk_sync_q[SYNC_STAGES-1];
        lrclk_hist_d = lrclk_sync_q[SYNC_STAGES-1];
    end

    assign bclk_fall  = bclk_hist_q & ~bclk_sync_q[SYNC_STAGES-1];
    assign lrclk_rise = ~lrclk_hist_q & lrclk_sync_q[SYNC_STAGES-1];
    assign lrclk_fall = lrclk_hist_q & ~lrclk_sync_q[SYNC_STAGES-1];

    assign left_word = i_valid ? i_sample : 16'h0000;
`ifdef DAC_STEREO_DUP_EN
    assign right_word = left_word;
`else
    assign right_word = 16'h0000;
`endif

    // An LRCLK edge always wins over a coincident BCLK fall; that fall is not
    // consumed, so the MSB waits for the next fall (I2S one-bit delay).
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        dacdat_d = dacdat_q;
        if (lrclk_rise || lrclk_fall) begin
            state_d  = ST_WAIT;
            shift_d  = lrclk_rise ? right_word : left_word;
            cnt_d    = 4'd0;
            dacdat_d = 1'b0;
        end else if (bclk_fall) begin
            case (state_q)
                ST_WAIT: begin
                    state_d  = ST_SEND;
                    dacdat_d = shift_q[15];
                    shift_d  = {shift_q[14:0], 1'b0};
                    cnt_d    = 4'd0;
                end
                ST_SEND: begin
                    if (cnt_q == 4'd15) begin
                        state_d  = ST_DONE;
                        dacdat_d = 1'b0;
                    end else begin
                        dacdat_d = shift_q[15];
                        shift_d  = {shift_q[14:0], 1'b0};
                        cnt_d    = cnt_q + 4'd1;
                    end
                end
                default: begin
                    dacdat_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pos_d  = lrclk_rise;
        neg_d  = lrclk_fall;
        busy_d = (state_q == ST_WAIT) || (state_q == ST_SEND);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            bclk_hist_q  <= 1'b0;
            lrclk_hist_q <= 1'b0;
            state_q      <= ST_IDLE;
            shift_q      <= 16'h0000;
            cnt_q        <= 4'd0;
            dacdat_q     <= 1'b0;
            pos_q        <= 1'b0;
            neg_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lrclk_sync_q <= lrclk_sync_d;
            bclk_hist_q  <= bclk_hist_d;
            lrclk_hist_q <= lrclk_hist_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            dacdat_q     <= dacdat_d;
            pos_q        <= pos_d;
            neg_q        <= neg_d;
            busy_q       <= busy_d;
        end
    end

    assign o_dacdat        = dacdat_q;
    assign o_lrclk_posedge = pos_q;
    assign o_lrclk_negedge = neg_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - randomized self-checking bench for i2s_dac_serializer.
module tb_i2s_dac_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bclk;
    logic        lrclk;
    logic        valid;
    logic [15:0] sample;
    logic        dacdat;
    logic        lr_pos;
    logic        lr_neg;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    // Reference model: word captured at the last LRCLK edge and number of
    // BCLK falls seen since that edge.
    logic [15:0] m_word;
    int          m_fall;
    bit          m_armed;
    int          exp_pos = 0;
    int          exp_neg = 0;
    int          seen_pos = 0;
    int          seen_neg = 0;

    i2s_dac_serializer #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .i_rst           (rst),
        .i_bclk          (bclk),
        .i_lrclk         (lrclk),
        .i_valid         (valid),
        .i_sample        (sample),
        .o_dacdat        (dacdat),
        .o_lrclk_posedge (lr_pos),
        .o_lrclk_negedge (lr_neg),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lr_pos) seen_pos++;
        if (lr_neg) seen_neg++;
    end

    function automatic logic [15:0] slot_word(input logic right, input logic v, input logic [15:0] s);
        logic [15:0] w;
        w = v ? s : 16'h0000;
`ifndef DAC_STEREO_DUP_EN
        if (right) w = 16'h0000;
`endif
        return w;
    endfunction

    function automatic logic exp_dac();
        if (m_armed && m_fall >= 1 && m_fall <= 16) return m_word[16-m_fall];
        return 1'b0;
    endfunction

    function automatic logic exp_busy();
        return m_armed && (m_fall <= 16);
    endfunction

    // One BCLK period (8 clk); the fall may coincide with an LRCLK change.
    task automatic step(input logic lr_new, input logic val_new, input logic [15:0] smp_new);
        logic lr_edge;
        logic e_dac;
        logic e_busy;
        @(posedge clk);
        #1;
        lr_edge = (lr_new !== lrclk);
        if (lr_edge) begin
            valid  = val_new;
            sample = smp_new;
        end
        bclk  = 1'b0;
        lrclk = lr_new;
        if (!rst) begin
            if (lr_edge) begin
                m_armed = 1'b1;
                m_fall  = 0;
                m_word  = slot_word(lr_new, val_new, smp_new);
                if (lr_new) exp_pos++; else exp_neg++;
            end else if (m_armed) begin
                m_fall++;
            end
        end
        e_dac  = rst ? 1'b0 : exp_dac();
        e_busy = rst ? 1'b0 : exp_busy();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (lr_pos !== 1'b0 || lr_neg !== 1'b0) begin
            errors++;
            $display("FAIL pulse_early got pos=%b neg=%b exp 0/0", lr_pos, lr_neg);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dacdat !== e_dac) begin
            errors++;
            $display("FAIL dacdat fall=%0d word=%h got=%b exp=%b", m_fall, m_word, dacdat, e_dac);
        end
        vectors++;
        if (lr_pos !== (lr_edge && lr_new && !rst) || lr_neg !== (lr_edge && !lr_new && !rst)) begin
            errors++;
            $display("FAIL pulse_timing got pos=%b neg=%b exp pos=%b neg=%b", lr_pos, lr_neg,
                     lr_edge && lr_new && !rst, lr_edge && !lr_new && !rst);
        end
        @(posedge clk);
        #1;
        bclk   = 1'b1;
        sample = 16'($urandom);
        valid  = 1'($urandom_range(0, 1));
        @(negedge clk);
        vectors++;
        if (busy !== e_busy) begin
            errors++;
            $display("FAIL busy fall=%0d got=%b exp=%b", m_fall, busy, e_busy);
        end
        vectors++;
        if (lr_pos !== 1'b0 || lr_neg !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width got pos=%b neg=%b exp 0/0", lr_pos, lr_neg);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic frame(input logic lr, input logic v, input logic [15:0] s, input int nbits);
        step(lr, v, s);
        for (int i = 1; i < nbits; i++) step(lr, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1; bclk = 1'b1; lrclk = 1'b0; valid = 1'b0; sample = 16'h0000;
        m_armed = 1'b0; m_fall = 0; m_word = 16'h0000;
        #1;
        vectors++;
        if ({dacdat, lr_pos, lr_neg, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000", {dacdat, lr_pos, lr_neg, busy});
        end
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hFFFF);
    endtask

    task automatic test_right_slot();
        frame(1'b1, 1'b1, 16'h8001, 20);
    endtask

    task automatic test_left_word();
        frame(1'b0, 1'b1, 16'hA5C3, 20);
        frame(1'b1, 1'b1, 16'h1234, 18);
    endtask

    task automatic test_invalid();
        frame(1'b0, 1'b0, 16'h7FFF, 20);
        frame(1'b1, 1'b0, 16'h7FFF, 18);
    endtask

    task automatic test_short_frame();
        frame(1'b0, 1'b1, 16'hFFFF, 9);
        frame(1'b1, 1'b1, 16'h0000, 18);
        frame(1'b0, 1'b1, 16'hC3A5, 18);
    endtask

    task automatic test_mid_reset();
        frame(1'b1, 1'b1, 16'h5555, 18);
        frame(1'b0, 1'b1, 16'hFFFF, 5);
        @(negedge clk);
        vectors++;
        if (dacdat !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got dac=%b busy=%b exp 1/1", dacdat, busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({dacdat, lr_pos, lr_neg, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0000", {dacdat, lr_pos, lr_neg, busy});
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_armed = 1'b0;
        m_fall  = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'hFFFF);
        frame(1'b1, 1'b1, 16'h9AB7, 18);
    endtask

    task automatic test_random();
        logic lr;
        lr = 1'b0;
        for (int f = 0; f < 14; f++) begin
            frame(lr, 1'($urandom_range(0, 3) != 0), 16'($urandom), int'($urandom_range(4, 22)));
            lr = ~lr;
        end
    endtask

    task automatic test_pulse_count();
        vectors++;
        if (seen_pos !== exp_pos || seen_neg !== exp_neg) begin
            errors++;
            $display("FAIL pulse_count got pos=%0d neg=%0d exp pos=%0d neg=%0d",
                     seen_pos, seen_neg, exp_pos, exp_neg);
        end
    endtask

    initial begin
        test_reset();
        test_right_slot();
        test_left_word();
        test_invalid();
        test_short_frame();
        test_mid_reset();
        test_random();
        test_pulse_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
